// File: rtl/sdp_ram_burst_writer.sv
// Burst write controller for port A of the simple dual-port RAM: command (addr, len-1) then valid/ready beats.
// Optional XOR checksum of accepted beats enabled by defining WR_CHECKSUM_EN.
module sdp_ram_burst_writer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  abort,
  output logic                  wena,
  output logic [ADDR_WIDTH-1:0] waddra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  done,
  output logic                  last_abort
`ifdef WR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_cmd_acc;
  logic                  w_hs;
  logic                  w_s_ready;
  logic                  w_cmd_ready;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_wena;
  logic [ADDR_WIDTH-1:0] r_waddra;
  logic [DATA_WIDTH-1:0] r_dina;
  logic                  r_last_abort;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_acc   = 1'b0;
    w_hs        = 1'b0;
    w_s_ready   = 1'b0;
    w_cmd_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cmd_acc   = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // abort blocks the beat in the same cycle, so an abort never races a final write
        w_s_ready = !abort;
        w_hs      = s_valid && !abort;
        if (abort) begin
          w_state_nxt = S_DONE;
        end else if (w_hs && (r_cnt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wena       <= 1'b0;
      r_waddra     <= '0;
      r_dina       <= '0;
      r_last_abort <= 1'b0;
    end else begin
      r_wena <= w_hs;
      if (w_cmd_acc) begin
        r_addr       <= cmd_addr;
        r_cnt        <= cmd_len;
        r_last_abort <= 1'b0;
      end
      if (w_hs) begin
        r_waddra <= r_addr;
        r_dina   <= s_data;
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - LEN_WIDTH'(1);
        end
      end
      if ((r_state == S_WRITE) && abort) begin
        r_last_abort <= 1'b1;
      end
    end
  end

`ifdef WR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_cmd_acc) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ s_data;
    end
  end

  assign csum = r_csum;
`endif

  assign cmd_ready  = w_cmd_ready;
  assign s_ready    = w_s_ready;
  assign wena       = r_wena;
  assign waddra     = r_waddra;
  assign dina       = r_dina;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign last_abort = r_last_abort;

endmodule

// File: tb/tb_sdp_ram_burst_writer.sv
// Directed bench for sdp_ram_burst_writer; a behavioural port-A memory captures writes for read-back.
module tb_sdp_ram_burst_writer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 7;
  localparam int unsigned LW = 8;

  logic          clka = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          abort;
  logic          wena;
  logic [AW-1:0] waddra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          done;
  logic          last_abort;
`ifdef WR_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]    t3_pat = 7'b1011001;
  logic [AW-1:0] t3_addr [7] = '{7'h20, 7'h20, 7'h20, 7'h21, 7'h22, 7'h22, 7'h23};
  logic [DW-1:0] t3_data [7] = '{8'hB0, 8'hB0, 8'hB0, 8'hB3, 8'hB4, 8'hB4, 8'hB6};

  always #5 clka = ~clka;

  sdp_ram_burst_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .abort     (abort),
    .wena      (wena),
    .waddra    (waddra),
    .dina      (dina),
    .busy      (busy),
    .done      (done),
    .last_abort(last_abort)
`ifdef WR_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
    if (wena === 1'b1) mem[waddra] = dina;
  endtask

  task automatic send_cmd(input string tag, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int b;
    b         = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    while (!cmd_ready && b < 20) begin
      tick();
      b++;
    end
    check_val({tag, "_cmd_wait"}, 32'(b < 20), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic beat(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic en, input logic [AW-1:0] a, input logic [DW-1:0] dt);
    s_valid = v;
    s_data  = d;
    tick();
    check_val({tag, "_wena"}, 32'(wena), 32'(en));
    check_val({tag, "_waddra"}, 32'(waddra), 32'(a));
    check_val({tag, "_dina"}, 32'(dina), 32'(dt));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    abort     = 1'b0;
    #23;
    check_val("rst_wena", 32'(wena), 32'd0);
    check_val("rst_waddra", 32'(waddra), 32'd0);
    check_val("rst_dina", 32'(dina), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_last_abort", 32'(last_abort), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Test 1: basic 4-word burst
    send_cmd("t1", 7'h10, 8'd3);
    s_valid = 1'b1;
    s_data  = 8'hA0;
    #1;
    check_val("t1_s_ready", 32'(s_ready), 32'd1);
    beat("t1b0", 1'b1, 8'hA0, 1'b1, 7'h10, 8'hA0);
    check_val("t1b0_done", 32'(done), 32'd0);
    beat("t1b1", 1'b1, 8'hA1, 1'b1, 7'h11, 8'hA1);
    beat("t1b2", 1'b1, 8'hA2, 1'b1, 7'h12, 8'hA2);
    beat("t1b3", 1'b1, 8'hA3, 1'b1, 7'h13, 8'hA3);
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_cmd_ready_done", 32'(cmd_ready), 32'd0);
`ifdef WR_CHECKSUM_EN
    check_val("t1_csum", 32'(csum), 32'h00);
`endif
    s_valid = 1'b0;
    tick();
    check_val("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("t1_done_end", 32'(done), 32'd0);
    check_val("t1_wena_end", 32'(wena), 32'd0);
    check_val("t1_busy_end", 32'(busy), 32'd0);
    check_val("t1_waddra_hold", 32'(waddra), 32'h13);

    // Test 2: address wrap and memory read-back
    send_cmd("t2", 7'h7E, 8'd3);
    beat("t2b0", 1'b1, 8'h11, 1'b1, 7'h7E, 8'h11);
    beat("t2b1", 1'b1, 8'h22, 1'b1, 7'h7F, 8'h22);
    beat("t2b2", 1'b1, 8'h33, 1'b1, 7'h00, 8'h33);
    beat("t2b3", 1'b1, 8'h44, 1'b1, 7'h01, 8'h44);
    check_val("t2_done", 32'(done), 32'd1);
    s_valid = 1'b0;
    tick();
    check_val("t2_mem7e", 32'(mem[7'h7E]), 32'h11);
    check_val("t2_mem7f", 32'(mem[7'h7F]), 32'h22);
    check_val("t2_mem00", 32'(mem[7'h00]), 32'h33);
    check_val("t2_mem01", 32'(mem[7'h01]), 32'h44);

    // Test 3: backpressure, idle beats carry junk data that must be ignored
    send_cmd("t3", 7'h20, 8'd3);
    for (int i = 0; i < 7; i++) begin
      beat($sformatf("t3b%0d", i), t3_pat[i], 8'(8'hB0 + i), t3_pat[i], t3_addr[i], t3_data[i]);
    end
    check_val("t3_done", 32'(done), 32'd1);
    s_valid = 1'b0;
    tick();
    check_val("t3_cmd_ready", 32'(cmd_ready), 32'd1);

    // Test 4: single word, second command held during the burst
    send_cmd("t4", 7'h30, 8'd0);
    cmd_valid = 1'b1;
    cmd_addr  = 7'h40;
    cmd_len   = 8'd0;
    beat("t4b0", 1'b1, 8'h5A, 1'b1, 7'h30, 8'h5A);
    check_val("t4_done", 32'(done), 32'd1);
    check_val("t4_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    s_valid = 1'b0;
    tick();
    check_val("t4_cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check_val("t4_busy_idle", 32'(busy), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check_val("t4_second_busy", 32'(busy), 32'd1);
    beat("t4b1", 1'b1, 8'h77, 1'b1, 7'h40, 8'h77);
    check_val("t4_done2", 32'(done), 32'd1);
    s_valid = 1'b0;
    tick();

    // Test 5: abort after two beats
    send_cmd("t5", 7'h50, 8'd7);
    beat("t5b0", 1'b1, 8'hC0, 1'b1, 7'h50, 8'hC0);
    beat("t5b1", 1'b1, 8'hC1, 1'b1, 7'h51, 8'hC1);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hC2;
    #1;
    check_val("t5_s_ready_abort", 32'(s_ready), 32'd0);
    beat("t5ab", 1'b1, 8'hC2, 1'b0, 7'h51, 8'hC1);
    check_val("t5_done", 32'(done), 32'd1);
    check_val("t5_last_abort", 32'(last_abort), 32'd1);
`ifdef WR_CHECKSUM_EN
    check_val("t5_csum", 32'(csum), 32'h01);
`endif
    abort   = 1'b0;
    s_valid = 1'b0;
    tick();
    check_val("t5_done_end", 32'(done), 32'd0);
    check_val("t5_last_abort_hold", 32'(last_abort), 32'd1);
    send_cmd("t5n", 7'h60, 8'd0);
    check_val("t5_last_abort_clr", 32'(last_abort), 32'd0);
    beat("t5nb", 1'b1, 8'h09, 1'b1, 7'h60, 8'h09);
    s_valid = 1'b0;
    tick();

    // Test 6: reset in the middle of a burst
    send_cmd("t6", 7'h08, 8'd7);
    beat("t6b0", 1'b1, 8'hD0, 1'b1, 7'h08, 8'hD0);
    beat("t6b1", 1'b1, 8'hD1, 1'b1, 7'h09, 8'hD1);
    beat("t6b2", 1'b1, 8'hD2, 1'b1, 7'h0A, 8'hD2);
    rst_n = 1'b0;
    #1;
    check_val("t6_wena_rst", 32'(wena), 32'd0);
    check_val("t6_busy_rst", 32'(busy), 32'd0);
    check_val("t6_cmd_ready_rst", 32'(cmd_ready), 32'd1);
    check_val("t6_done_rst", 32'(done), 32'd0);
    check_val("t6_s_ready_rst", 32'(s_ready), 32'd0);
    tick();
    check_val("t6_done_hold", 32'(done), 32'd0);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    check_val("t6_mem0a", 32'(mem[7'h0A]), 32'hD2);
    send_cmd("t6n", 7'h00, 8'd0);
    beat("t6nb", 1'b1, 8'hE5, 1'b1, 7'h00, 8'hE5);
    check_val("t6_done", 32'(done), 32'd1);
`ifdef WR_CHECKSUM_EN
    check_val("t6_csum", 32'(csum), 32'hE5);
`endif
    s_valid = 1'b0;
    tick();
    check_val("t6_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
